// File: rtl/enc_trig_pkg.sv
// enc_trig_pkg: shared types and default constants
// for the encoder line trigger.
package enc_trig_pkg;

   localparam int DEB_CYCLES_DEF = 50;
   localparam int CNT_W_DEF      = 32;
   localparam int MULT_W_DEF     = 16;
   localparam int PW_W_DEF       = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      RUN  = 2'd2
   } trigState_t;

endpackage

// File: rtl/enc_trig_div.sv
// enc_trig_div: restoring divider, one quotient bit
// per cycle; quotient holds until the next start.
module enc_trig_div
   import enc_trig_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             fclk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic             done,
   output logic [CNT_W-1:0] quotient
);

   localparam int STEP_W = $clog2(CNT_W + 1);

   logic [CNT_W-1:0]  rem;
   logic [STEP_W-1:0] stepsLeft;
   logic              running;
   logic [CNT_W:0]    shifted;
   logic              fits;

   // Partial remainder shifted by one dividend bit
   always_comb begin
      shifted = {rem, quotient[CNT_W-1]};
      fits    = shifted >= {1'b0, divisor};
   end

   // Iteration: a start always restarts from scratch
   always_ff @(posedge fclk) begin
      if (rst) begin
         running   <= 1'b0;
         done      <= 1'b0;
         rem       <= '0;
         quotient  <= '0;
         stepsLeft <= '0;
      end else if (start) begin
         running   <= 1'b1;
         done      <= 1'b0;
         rem       <= '0;
         quotient  <= dividend;
         stepsLeft <= STEP_W'(CNT_W);
      end else if (running) begin
         rem       <= fits ? shifted[CNT_W-1:0] - divisor
                           : shifted[CNT_W-1:0];
         quotient  <= {quotient[CNT_W-2:0], fits};
         stepsLeft <= stepsLeft - STEP_W'(1);
         if (stepsLeft == STEP_W'(1)) begin
            running <= 1'b0;
            done    <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/encoder_line_trigger.sv
// encoder_line_trigger: quadrature decode, interpolated line triggers.
// ENC_TRIG_POSITION_EN builds the position counter (else position=0).
module encoder_line_trigger
   import enc_trig_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int MULT_W     = MULT_W_DEF,
   parameter int PW_W       = PW_W_DEF
) (
   input  logic              fclk,
   input  logic              rst,
   input  logic              enc_a,
   input  logic              enc_b,
   input  logic              enable,
   input  logic              x4_mode,
   input  logic              rev_comp,
   input  logic [MULT_W-1:0] mult,
   input  logic [PW_W-1:0]   pulse_len,
   input  logic              clr_status,
   output logic              trig_out,
   output logic              dir,
   output logic [CNT_W-1:0]  position,
   output logic              err_illegal,
   output logic              overrun,
   output logic              busy
);

   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       syncA;
   logic [1:0]       syncB;
   logic [1:0]       rawLvl;
   logic [1:0]       debLvl;
   logic [1:0]       prevLvl;
   logic [DEB_W-1:0] debCnt [2];

   logic             chA;
   logic             chB;
   logic             illegal;
   logic             step;
   logic             stepFwd;
   logic             qual;
   logic [CNT_W-1:0] rewind;

   logic [CNT_W-1:0] perCnt;
   logic             haveQual;
   logic             divStart;
   logic             divDone;
   logic [CNT_W-1:0] quo;
   logic [CNT_W-1:0] ivEff;
   logic [CNT_W-1:0] ivCnt;

   logic [MULT_W-1:0] multEff;
   logic [MULT_W-1:0] multM1;
   logic [MULT_W-1:0] extraCnt;

   trigState_t       state;
   trigState_t       nextState;
   logic             fire;
   logic             req;
   logic [PW_W-1:0]  pwEff;
   logic [PW_W-1:0]  pulseLeft;

   assign rawLvl   = {syncB[1], syncA[1]};
   assign multEff  = (mult == '0) ? MULT_W'(1) : mult;
   assign multM1   = multEff - MULT_W'(1);
   assign ivEff    = (quo == '0) ? CNT_W'(1) : quo;
   assign pwEff    = (pulse_len == '0) ? PW_W'(1) : pulse_len;
   assign divStart = qual & enable & haveQual;
   assign req      = enable & (qual | fire);
   assign busy     = (state != IDLE);

   // Two-flop synchronizers for the async encoder lines
   always_ff @(posedge fclk) begin
      if (rst) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= {syncA[0], enc_a};
         syncB <= {syncB[0], enc_b};
      end
   end

   // Debounce: adopt a new level after DEB_CYCLES steady samples
   always_ff @(posedge fclk) begin
      if (rst) begin
         debLvl    <= '0;
         prevLvl   <= '0;
         debCnt[0] <= '0;
         debCnt[1] <= '0;
      end else begin
         prevLvl <= debLvl;
         for (int i = 0; i < 2; i++) begin
            if (rawLvl[i] == debLvl[i]) begin
               debCnt[i] <= '0;
            end else if (debCnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
               debLvl[i] <= rawLvl[i];
               debCnt[i] <= '0;
            end else begin
               debCnt[i] <= debCnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Step decode; forward means A leads B
   always_comb begin
      chA     = debLvl[0] ^ prevLvl[0];
      chB     = debLvl[1] ^ prevLvl[1];
      illegal = chA & chB;
      step    = 1'b0;
      stepFwd = 1'b0;
      if (!illegal) begin
         if (chA) begin
            step    = 1'b1;
            stepFwd = debLvl[0] ^ debLvl[1];
         end else if (chB && x4_mode) begin
            step    = 1'b1;
            stepFwd = ~(debLvl[0] ^ debLvl[1]);
         end
      end
      qual = step & (~rev_comp | (stepFwd & (rewind == '0)));
   end

   // Direction and reverse-motion bookkeeping
   always_ff @(posedge fclk) begin
      if (rst) begin
         dir    <= 1'b1;
         rewind <= '0;
      end else if (step) begin
         dir <= stepFwd;
         if (rev_comp) begin
            if (!stepFwd && rewind != CNT_MAX)
               rewind <= rewind + CNT_W'(1);
            else if (stepFwd && rewind != '0)
               rewind <= rewind - CNT_W'(1);
         end
      end
   end

`ifdef ENC_TRIG_POSITION_EN
   logic [CNT_W-1:0] posCnt;

   // Signed step count, wraps naturally
   always_ff @(posedge fclk) begin
      if (rst)
         posCnt <= '0;
      else if (step)
         posCnt <= stepFwd ? posCnt + CNT_W'(1)
                           : posCnt - CNT_W'(1);
   end

   assign position = posCnt;
`else
   assign position = '0;
`endif

   // Cycles since the last qualifying step, saturating
   always_ff @(posedge fclk) begin
      if (rst) begin
         perCnt   <= '0;
         haveQual <= 1'b0;
      end else if (qual) begin
         perCnt   <= CNT_W'(1);
         haveQual <= 1'b1;
      end else if (perCnt != CNT_MAX) begin
         perCnt <= perCnt + CNT_W'(1);
      end
   end

   enc_trig_div #(
      .CNT_W(CNT_W)
   ) uDiv (
      .fclk    (fclk),
      .rst     (rst),
      .start   (divStart),
      .dividend(perCnt),
      .divisor (CNT_W'(multEff)),
      .done    (divDone),
      .quotient(quo)
   );

   // Interpolator state register
   always_ff @(posedge fclk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Interpolator next state and extra-trigger strobe
   always_comb begin
      nextState = state;
      fire      = 1'b0;
      unique case (state)
         IDLE: nextState = IDLE;
         DIV:  if (divDone) nextState = RUN;
         RUN: begin
            if (extraCnt >= multM1)
               nextState = IDLE;
            else if (ivCnt >= ivEff)
               fire = 1'b1;
         end
         default: nextState = IDLE;
      endcase
      if (divStart)
         nextState = DIV;
      if (!enable) begin
         nextState = IDLE;
         fire      = 1'b0;
      end
   end

   // Interval timer measured from the step, plus extra count
   always_ff @(posedge fclk) begin
      if (rst) begin
         ivCnt    <= '0;
         extraCnt <= '0;
      end else if (divStart) begin
         ivCnt    <= CNT_W'(1);
         extraCnt <= '0;
      end else if (fire) begin
         ivCnt    <= ivCnt - ivEff + CNT_W'(1);
         extraCnt <= extraCnt + MULT_W'(1);
      end else if (ivCnt != CNT_MAX) begin
         ivCnt <= ivCnt + CNT_W'(1);
      end
   end

   // Pulse stretcher and sticky status flags
   always_ff @(posedge fclk) begin
      if (rst) begin
         trig_out    <= 1'b0;
         pulseLeft   <= '0;
         err_illegal <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (req && !trig_out) begin
            trig_out  <= 1'b1;
            pulseLeft <= pwEff - PW_W'(1);
         end else if (trig_out) begin
            if (pulseLeft == '0)
               trig_out <= 1'b0;
            else
               pulseLeft <= pulseLeft - PW_W'(1);
         end
         err_illegal <= illegal | (err_illegal & ~clr_status);
         overrun     <= (req & trig_out) | (overrun & ~clr_status);
      end
   end

endmodule

// File: tb/tb_encoder_line_trigger.sv
// tb_encoder_line_trigger: scenario tasks with a pulse
// scoreboard for encoder_line_trigger.
module tb_encoder_line_trigger;

   localparam int CNT_W  = 32;
   localparam int MULT_W = 16;
   localparam int PW_W   = 8;

   logic              fclk = 1'b0;
   logic              rst;
   logic              enc_a;
   logic              enc_b;
   logic              enable;
   logic              x4_mode;
   logic              rev_comp;
   logic [MULT_W-1:0] mult;
   logic [PW_W-1:0]   pulse_len;
   logic              clr_status;
   logic              trig_out;
   logic              dir;
   logic [CNT_W-1:0]  position;
   logic              err_illegal;
   logic              overrun;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int len;
      int gap;
   } pulse_t;

   pulse_t expQ[$];

   logic [1:0] phase;
   int posModel;

   logic   prevTrig = 1'b0;
   int     startCyc = 0;
   int     lastStart = 0;
   int     mLen;
   int     mGap;
   pulse_t mExp;

   encoder_line_trigger dut (
      .fclk       (fclk),
      .rst        (rst),
      .enc_a      (enc_a),
      .enc_b      (enc_b),
      .enable     (enable),
      .x4_mode    (x4_mode),
      .rev_comp   (rev_comp),
      .mult       (mult),
      .pulse_len  (pulse_len),
      .clr_status (clr_status),
      .trig_out   (trig_out),
      .dir        (dir),
      .position   (position),
      .err_illegal(err_illegal),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 fclk = ~fclk;

   always @(posedge fclk) cyc++;

   // Pulse monitor: pop the scoreboard on every completed pulse
   always @(negedge fclk) begin
      if (trig_out === 1'b1 && prevTrig === 1'b0)
         startCyc = cyc;
      if (trig_out === 1'b0 && prevTrig === 1'b1) begin
         mLen = cyc - startCyc;
         mGap = startCyc - lastStart;
         lastStart = startCyc;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse len %0d at cycle %0d, required none",
                     mLen, cyc);
         end else begin
            mExp = expQ.pop_front();
            if (mExp.len >= 0 && mLen != mExp.len) begin
               errors++;
               $display("FAIL pulse_len got %0d required %0d", mLen, mExp.len);
            end
            if (mExp.gap >= 0) begin
               checks++;
               if (mGap < mExp.gap - 2 || mGap > mExp.gap + 2) begin
                  errors++;
                  $display("FAIL pulse_gap got %0d required %0d", mGap, mExp.gap);
               end
            end
         end
      end
      prevTrig = trig_out;
   end

   function automatic logic [31:0] expPos();
`ifdef ENC_TRIG_POSITION_EN
      return 32'(posModel);
`else
      return 32'(posModel & 0);
`endif
   endfunction

   task automatic resetDut();
      enc_a = 1'b0;
      enc_b = 1'b0;
      phase = 2'b00;
      posModel = 0;
      enable = 1'b1;
      x4_mode = 1'b1;
      rev_comp = 1'b0;
      mult = 16'd1;
      pulse_len = 8'd4;
      clr_status = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge fclk);
      #1 rst = 1'b0;
      repeat (3) @(posedge fclk);
      #1;
   endtask

   task automatic moveEdge(input bit fwd, input int waitCyc);
      logic [1:0] nxt;
      if (fwd)
         case (phase)
            2'b00: nxt = 2'b10;
            2'b10: nxt = 2'b11;
            2'b11: nxt = 2'b01;
            default: nxt = 2'b00;
         endcase
      else
         case (phase)
            2'b00: nxt = 2'b01;
            2'b01: nxt = 2'b11;
            2'b11: nxt = 2'b10;
            default: nxt = 2'b00;
         endcase
      if (x4_mode || nxt[1] != phase[1])
         posModel += fwd ? 1 : -1;
      phase = nxt;
      enc_a = phase[1];
      enc_b = phase[0];
      repeat (waitCyc) @(posedge fclk);
      #1;
   endtask

   task automatic test_reset();
      enc_a = 1'b0;
      enc_b = 1'b0;
      enable = 1'b1;
      x4_mode = 1'b1;
      rev_comp = 1'b0;
      mult = 16'd1;
      pulse_len = 8'd4;
      clr_status = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge fclk);
      @(negedge fclk);
      checks++;
      if (trig_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_trig got %b required 0", trig_out);
      end
      checks++;
      if (dir !== 1'b1) begin
         errors++;
         $display("FAIL reset_dir got %b required 1", dir);
      end
      checks++;
      if (position !== 32'd0) begin
         errors++;
         $display("FAIL reset_position got %0d required 0", position);
      end
      checks++;
      if (err_illegal !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got %b%b required 00", err_illegal, overrun);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b required 0", busy);
      end
      rst = 1'b0;
      @(posedge fclk);
      #1;
   endtask

   task automatic test_glitch();
      resetDut();
      enc_a = 1'b1;
      repeat (20) @(posedge fclk);
      #1 enc_a = 1'b0;
      repeat (200) @(posedge fclk);
      #1;
      checks++;
      if (position !== 32'd0) begin
         errors++;
         $display("FAIL glitch_position got %0d required 0", position);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL glitch_pending got %0d required 0", expQ.size());
      end
   endtask

   task automatic test_x4_basic();
      resetDut();
      expQ.push_back('{len: 4, gap: -1});
      for (int i = 0; i < 3; i++)
         expQ.push_back('{len: 4, gap: 200});
      for (int i = 0; i < 4; i++)
         moveEdge(1'b1, 200);
      repeat (200) @(posedge fclk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL x4_missing got %0d required 0", expQ.size());
      end
      checks++;
      if (position !== expPos()) begin
         errors++;
         $display("FAIL x4_position got %0d required %0d", position, expPos());
      end
      checks++;
      if (dir !== 1'b1) begin
         errors++;
         $display("FAIL x4_dir got %b required 1", dir);
      end
   endtask

   task automatic test_interp();
      resetDut();
      x4_mode = 1'b0;
      mult = 16'd4;
      expQ.push_back('{len: 4, gap: -1});
      expQ.push_back('{len: 4, gap: 1000});
      for (int i = 0; i < 7; i++)
         expQ.push_back('{len: 4, gap: 250});
      for (int i = 0; i < 6; i++)
         moveEdge(1'b1, 500);
      repeat (1200) @(posedge fclk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL interp_missing got %0d required 0", expQ.size());
      end
      checks++;
      if (position !== expPos()) begin
         errors++;
         $display("FAIL interp_position got %0d required %0d", position, expPos());
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL interp_busy got %b required 0", busy);
      end
   endtask

   task automatic test_rev();
      resetDut();
      rev_comp = 1'b1;
      for (int i = 0; i < 3; i++)
         moveEdge(1'b0, 200);
      checks++;
      if (dir !== 1'b0) begin
         errors++;
         $display("FAIL rev_dir got %b required 0", dir);
      end
      expQ.push_back('{len: 4, gap: -1});
      expQ.push_back('{len: 4, gap: 200});
      for (int i = 0; i < 5; i++)
         moveEdge(1'b1, 200);
      repeat (200) @(posedge fclk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL rev_missing got %0d required 0", expQ.size());
      end
      checks++;
      if (position !== expPos()) begin
         errors++;
         $display("FAIL rev_position got %0d required %0d", position, expPos());
      end
   endtask

   task automatic test_illegal();
      resetDut();
      enc_a = 1'b1;
      enc_b = 1'b1;
      repeat (200) @(posedge fclk);
      #1;
      checks++;
      if (err_illegal !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag got %b required 1", err_illegal);
      end
      checks++;
      if (position !== 32'd0) begin
         errors++;
         $display("FAIL illegal_position got %0d required 0", position);
      end
      clr_status = 1'b1;
      @(posedge fclk);
      #1 clr_status = 1'b0;
      @(negedge fclk);
      checks++;
      if (err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear got %b required 0", err_illegal);
      end
   endtask

   task automatic test_overrun();
      resetDut();
      mult = 16'd4;
      pulse_len = 8'd200;
      expQ.push_back('{len: 200, gap: -1});
      expQ.push_back('{len: 200, gap: 400});
      expQ.push_back('{len: 200, gap: 300});
      moveEdge(1'b1, 400);
      moveEdge(1'b1, 400);
      repeat (800) @(posedge fclk);
      #1;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_flag got %b required 1", overrun);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL overrun_missing got %0d required 0", expQ.size());
      end
      clr_status = 1'b1;
      @(posedge fclk);
      #1 clr_status = 1'b0;
      @(negedge fclk);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear got %b required 0", overrun);
      end
   endtask

   task automatic test_zero_cfg();
      resetDut();
      mult = 16'd0;
      pulse_len = 8'd0;
      expQ.push_back('{len: 1, gap: -1});
      expQ.push_back('{len: 1, gap: 200});
      expQ.push_back('{len: 1, gap: 200});
      for (int i = 0; i < 3; i++)
         moveEdge(1'b1, 200);
      repeat (100) @(posedge fclk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL zero_missing got %0d required 0", expQ.size());
      end
   endtask

   task automatic test_enable();
      resetDut();
      enable = 1'b0;
      mult = 16'd2;
      for (int i = 0; i < 3; i++)
         moveEdge(1'b1, 200);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL enable_busy got %b required 0", busy);
      end
      checks++;
      if (position !== expPos()) begin
         errors++;
         $display("FAIL enable_position got %0d required %0d", position, expPos());
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL enable_pending got %0d required 0", expQ.size());
      end
   endtask

   task automatic test_reset_mid_pulse();
      int waited;
      resetDut();
      pulse_len = 8'd200;
      expQ.push_back('{len: -1, gap: -1});
      moveEdge(1'b1, 0);
      waited = 0;
      while (trig_out !== 1'b1 && waited < 300) begin
         @(negedge fclk);
         waited++;
      end
      checks++;
      if (trig_out !== 1'b1) begin
         errors++;
         $display("FAIL midrst_start got %b required 1 within 300", trig_out);
      end
      repeat (10) @(negedge fclk);
      rst = 1'b1;
      enc_a = 1'b0;
      enc_b = 1'b0;
      phase = 2'b00;
      @(posedge fclk);
      #1;
      checks++;
      if (trig_out !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_abort got %b%b required 00", trig_out, busy);
      end
      @(posedge fclk);
      #1 rst = 1'b0;
      repeat (100) @(posedge fclk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL midrst_pending got %0d required 0", expQ.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      enc_a = 1'b0;
      enc_b = 1'b0;
      enable = 1'b1;
      x4_mode = 1'b1;
      rev_comp = 1'b0;
      mult = 16'd1;
      pulse_len = 8'd4;
      clr_status = 1'b0;
      phase = 2'b00;
      posModel = 0;
      test_reset();
      test_glitch();
      test_x4_basic();
      test_interp();
      test_rev();
      test_illegal();
      test_overrun();
      test_zero_cfg();
      test_enable();
      test_reset_mid_pulse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/encoder_line_trigger.md
ENCODER_LINE_TRIGGER -- requirements
Module: encoder_line_trigger

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50: consecutive stable cycles required to accept an encoder input level.
REQ-002 SHALL have parameter CNT_W, default 32: width of the period, interval and position counters.
REQ-003 SHALL have parameter MULT_W, default 16: width of the interpolation multiplier.
REQ-004 SHALL have parameter PW_W, default 8: width of the trigger pulse-length field.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports: fclk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: enc_a in 1 and enc_b in 1, async quadrature inputs; enable in 1, gates trigger generation; x4_mode in 1, where 1 means every A/B edge is a step and 0 means only A rising/falling edges are steps.
REQ-007 SHALL have ports: rev_comp in 1, reverse-motion compensation on; mult in MULT_W, triggers per step; pulse_len in PW_W, trigger high time in cycles; clr_status in 1, clears sticky flags.
REQ-008 SHALL have outputs: trig_out 1, trigger pulse; dir 1, last step direction (1 = forward); position CNT_W, signed step count; err_illegal 1, sticky; overrun 1, sticky; busy 1, high while not IDLE.

Function
REQ-009 SHALL pass each input through a 2-FF synchronizer, then a debouncer that updates the debounced level only after DEB_CYCLES equal consecutive samples.
REQ-010 SHALL decode steps from the previous and current debounced A/B: forward is A leading B. If both levels change in the same cycle: set err_illegal, no step.
REQ-011 SHALL update position by +1 or -1 per step, wrapping modulo 2^CNT_W.
REQ-012 With rev_comp=1: each reverse step increments rewind; each forward step with rewind>0 decrements rewind and produces no trigger. rewind saturates at all-ones.
REQ-013 A qualifying step is a forward step with rewind==0, or any step when rev_comp=0.
REQ-014 SHALL measure the period as cycles between consecutive qualifying steps, saturating at 2^CNT_W-1.
REQ-015 Interpolator FSM states: IDLE, DIV, RUN.
REQ-016 IDLE -> DIV on a qualifying step once a period is valid (second qualifying step onward). DIV -> RUN when the divider is done. RUN -> IDLE when mult-1 extra triggers have issued. A qualifying step in any state restarts in DIV.
REQ-017 Each qualifying step SHALL request one trigger immediately. In RUN, an extra trigger SHALL be requested every interval = period/mult cycles, at most mult-1 per step.
REQ-018 mult=0 SHALL be treated as 1. An interval result of 0 SHALL be treated as 1.
REQ-019 Trigger requests SHALL drive trig_out high 1 cycle after the request, for max(pulse_len,1) cycles.
REQ-020 A request arriving while trig_out is high SHALL be dropped and set overrun.
REQ-021 With enable=0: steps, position and period still track; no requests are issued; FSM is forced to IDLE.
REQ-022 clr_status SHALL clear err_illegal and overrun next cycle; a simultaneous set wins.

Reset
REQ-023 On rst: trig_out=0, dir=1, position=0, err_illegal=0, overrun=0, busy=0, rewind=0, period invalid, FSM in IDLE, debounced levels taken as 0.
REQ-024 rst asserted mid-pulse or mid-division SHALL abort it in the same cycle.

Configuration
REQ-025 Macro ENC_TRIG_POSITION_EN: when defined, position counting per REQ-011 is built. When undefined, position is tied to 0 and its counter is removed; all other behaviour is unchanged.

Structure
REQ-026 Package enc_trig_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-027 Sub-module enc_trig_div: sequential restoring divider, CNT_W cycles, start/done handshake; the quotient is held until the next start.

Verification
REQ-028 rst=1 for 3 cycles -> all outputs at REQ-023 values.
REQ-029 A glitch of 20 cycles on enc_a with DEB_CYCLES=50 -> no step; position stays 0.
REQ-030 x4_mode=1, four forward quadrature edges spaced 200 cycles, mult=1, pulse_len=4 -> position=4, four 4-cycle pulses.
REQ-031 Forward steps every 1000 cycles with mult=4 -> after the second step, pulses at the step and about 250, 500, 750 cycles after it.
REQ-032 rev_comp=1, 3 reverse steps then 5 forward steps -> only the last 2 forward steps trigger; position=+2.
REQ-033 A and B toggled in the same cycle -> err_illegal=1, no step; clr_status -> 0. pulse_len=200 with interval 100 -> overrun=1.
